// File: rtl/fetch_unit.sv
// Instruction fetch: issues PC word fetches to imem, buffers in-order responses, feeds decode.
// Latency: a response registered at edge N appears on the decode outputs in cycle N+1 (two cycles after request accept with 1-cycle memory).
// Backpressure: decode stall holds the head entry; a full buffer drops req valid and stalls the PC; redirect flushes and drops stale responses.
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic        redirect_i,
  output logic        stall_o,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Outstanding/drop counters carry a full buffer of live fetches plus the
  // stale fetches left behind by earlier redirects, so they get headroom.
  localparam int CW = AW + 2;

  logic [31:0]      slot_pc    [DEPTH];
  logic [31:0]      slot_instr [DEPTH];
  logic [DEPTH-1:0] slot_filled;

  logic [AW-1:0] alloc_ptr;
  logic [AW-1:0] fill_ptr;
  logic [AW-1:0] head_ptr;
  logic [AW:0]   occ;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;

  logic full;
  logic req_fire;
  logic deq;
  logic rsp_ok;
  logic rsp_drop;
  logic rsp_fill;

  // Handshake and flow-control decode for this cycle
  always_comb begin
    full             = (occ == (AW+1)'(DEPTH));
    imem_req_valid_o = !reset && !redirect_i && !full;
    req_fire         = imem_req_valid_o && imem_req_ready_i;
    // PC holds unless a fetch was taken; a redirect must let the target load.
    stall_o          = !reset && !req_fire && !redirect_i;
    id_valid_o       = !reset && !redirect_i && (occ != '0) && slot_filled[head_ptr];
    deq              = id_valid_o && id_ready_i;
    // A response with nothing outstanding is illegal and is ignored.
    rsp_ok           = imem_rsp_valid_i && (out_cnt != '0);
    rsp_drop         = rsp_ok && (drop_cnt != '0);
    rsp_fill         = rsp_ok && (drop_cnt == '0) && !redirect_i;
  end

  assign imem_req_addr_o = pc_i;
  assign id_instr_o      = slot_instr[head_ptr];
  // While in reset the data outputs are don't-care; show the PC the register reloads to.
  assign id_pc_o         = reset ? RESET_PC : slot_pc[head_ptr];
  assign id_pc_plus4_o   = id_pc_o + 32'd4;

  // Buffer pointers, occupancy and outstanding/drop accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      occ       <= '0;
      out_cnt   <= '0;
      drop_cnt  <= '0;
    end else if (redirect_i) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      occ       <= '0;
      // Every fetch still in flight after this cycle's response is stale.
      out_cnt   <= out_cnt - CW'(rsp_ok);
      drop_cnt  <= out_cnt - CW'(rsp_ok);
    end else begin
      if (req_fire) alloc_ptr <= alloc_ptr + 1'b1;
      if (rsp_fill) fill_ptr  <= fill_ptr + 1'b1;
      if (deq)      head_ptr  <= head_ptr + 1'b1;
      occ     <= occ + (AW+1)'(req_fire) - (AW+1)'(deq);
      out_cnt <= out_cnt + CW'(req_fire) - CW'(rsp_ok);
      if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  // Per-slot filled flags: cleared on allocate, set when the response lands
  always_ff @(posedge clk) begin
    if (reset || redirect_i) begin
      slot_filled <= '0;
    end else begin
      // alloc_ptr always names a free slot and fill_ptr an allocated one, so they never collide.
      if (req_fire) slot_filled[alloc_ptr] <= 1'b0;
      if (rsp_fill) slot_filled[fill_ptr]  <= 1'b1;
    end
  end

  // Slot payload storage, qualified by the filled flags and occupancy
  always_ff @(posedge clk) begin
    if (req_fire) slot_pc[alloc_ptr]   <= pc_i;
    if (rsp_fill) slot_instr[fill_ptr] <= imem_rsp_data_i;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register, in-order memory and decode are modelled in the bench.
// Reference is a queue of pending fetch entries plus a stale-response count.
// Directed phases follow the plan, then a long randomized run.
module tb_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i;
  logic        redirect_i;
  logic        stall_o;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_plus4_o;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_i             (pc_i),
    .redirect_i       (redirect_i),
    .stall_o          (stall_o),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_instr_o       (id_instr_o),
    .id_pc_o          (id_pc_o),
    .id_pc_plus4_o    (id_pc_plus4_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          filled;
    logic [31:0] instr;
  } ent_t;

  ent_t        bq[$];        // allocated fetch entries, oldest first
  int          stale;        // responses still to be discarded
  int          mem_due[$];   // memory: response cycle per accepted request
  logic [31:0] mem_addr[$];  // memory: address per accepted request
  int          last_due;
  int          cyc;
  logic [31:0] pc_reg;       // PC register model
  int          n_cmp;
  int          n_bad;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs after the edge, check and advance the model mid-cycle.
  task automatic step(input bit rst, input bit redir, input logic [31:0] tgt,
                      input bit rrdy, input bit drdy, input int lat);
    bit          rsp;
    bit          exp_req;
    bit          exp_fire;
    bit          exp_idv;
    logic [31:0] rsp_dat;
    int          unfilled;
    ent_t        e;
    @(posedge clk);
    #1;
    cyc++;
    reset            = rst;
    redirect_i       = rst ? 1'b0 : redir;
    pc_i             = pc_reg;
    imem_req_ready_i = rrdy;
    id_ready_i       = drdy;
    rsp              = !rst && (mem_due.size() > 0) && (mem_due[0] <= cyc);
    rsp_dat          = rsp ? mem_word(mem_addr[0]) : $urandom;
    imem_rsp_valid_i = rsp;
    imem_rsp_data_i  = rsp_dat;
    @(negedge clk);
    if (rst) begin
      chk("rst_id_valid", {31'b0, id_valid_o}, 32'd0);
      chk("rst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
      chk("rst_stall", {31'b0, stall_o}, 32'd0);
      bq.delete();
      mem_due.delete();
      mem_addr.delete();
      stale    = 0;
      pc_reg   = RESET_PC;
      last_due = cyc;
      return;
    end
    if (rsp) begin
      void'(mem_due.pop_front());
      void'(mem_addr.pop_front());
    end
    exp_req  = !redir && (bq.size() < DEPTH);
    exp_fire = exp_req && rrdy;
    exp_idv  = !redir && (bq.size() > 0) && bq[0].filled;
    chk("req_valid", {31'b0, imem_req_valid_o}, {31'b0, exp_req});
    chk("req_addr", imem_req_addr_o, pc_reg);
    chk("stall", {31'b0, stall_o}, {31'b0, !exp_fire && !redir});
    chk("id_valid", {31'b0, id_valid_o}, {31'b0, exp_idv});
    if (exp_idv) begin
      chk("id_instr", id_instr_o, bq[0].instr);
      chk("id_pc", id_pc_o, bq[0].pc);
      chk("id_pc_plus4", id_pc_plus4_o, bq[0].pc + 32'd4);
    end
    if (redir) begin
      unfilled = 0;
      foreach (bq[i]) if (!bq[i].filled) unfilled++;
      stale  = stale + unfilled - int'(rsp);
      bq.delete();
      pc_reg = tgt;
    end else begin
      if (rsp) begin
        if (stale > 0) begin
          stale--;
        end else begin
          for (int i = 0; i < bq.size(); i++) begin
            if (!bq[i].filled) begin
              bq[i].filled = 1'b1;
              bq[i].instr  = rsp_dat;
              break;
            end
          end
        end
      end
      if (exp_idv && drdy) void'(bq.pop_front());
      if (exp_fire) begin
        e.pc     = pc_reg;
        e.filled = 1'b0;
        e.instr  = 32'h0;
        bq.push_back(e);
        pc_reg = pc_reg + 32'd4;
      end
    end
    if (exp_fire) begin
      last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      mem_due.push_back(last_due);
      mem_addr.push_back(imem_req_addr_o);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; stale = 0; last_due = 0;
    pc_reg = RESET_PC;
    reset = 1'b1; redirect_i = 1'b0; pc_i = RESET_PC;
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
    id_ready_i = 1'b0;

    // Reset, then straight-line fetch with 1-cycle memory and ready decode
    repeat (2) step(1, 0, 0, 1, 1, 1);
    repeat (12) step(0, 0, 0, 1, 1, 1);

    // Decode stalls five cycles, then drains
    repeat (5) step(0, 0, 0, 1, 0, 1);
    repeat (8) step(0, 0, 0, 1, 1, 1);

    // Memory ready toggling 1,0,0,1
    repeat (3) begin
      step(0, 0, 0, 1, 1, 1);
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1, 1);
    end

    // Redirect to 0x100 with two fetches outstanding at 3-cycle latency
    repeat (2) step(1, 0, 0, 1, 1, 3);
    repeat (2) step(0, 0, 0, 1, 1, 3);
    step(0, 1, 32'h0000_0100, 1, 1, 3);
    repeat (12) step(0, 0, 0, 1, 1, 3);

    // Redirect coinciding with a response, then a second redirect
    repeat (2) step(1, 0, 0, 1, 1, 2);
    repeat (2) step(0, 0, 0, 1, 1, 2);
    step(0, 1, 32'h0000_0040, 1, 1, 2);
    step(0, 1, 32'h0000_0080, 1, 1, 2);
    repeat (10) step(0, 0, 0, 1, 1, 1);

    // Reset while the buffer is full; fetch restarts at the reset PC
    repeat (4) step(0, 0, 0, 1, 0, 1);
    repeat (2) step(1, 0, 0, 1, 1, 1);
    repeat (8) step(0, 0, 0, 1, 1, 1);

    // Address wrap at the top of memory
    step(0, 1, 32'hFFFF_FFF8, 1, 1, 1);
    repeat (10) step(0, 0, 0, 1, 1, 1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 11) == 0,
           tgt,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
